uc_multiciclo: RTL

Multicycle control unit for the single-cycle microcontroller datapath. It consumes `Opcode` and `z` from the datapath and drives `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It adds a PC write enable, run/single-step control, a HALT state, an illegal-opcode flag and a retired-instruction counter. Each instruction takes a FETCH cycle and an EXEC cycle, so the datapath's PC, register file and zero flip-flop update only in EXEC.

---
 rtl/uc_pkg.sv | 24 ++
 rtl/uc_decoder.sv | 53 +++++
 rtl/uc_multiciclo.sv | 119 +++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the multicycle control unit.
//   - Opcode-class constants, matched against Opcode[5:2].
//     ALU instructions are recognised by Opcode[5] alone.
//   - State enum of the control FSM.
//     The encoding is also visible on the top-level dbg_state port.
package uc_pkg;

  localparam logic [3:0] OPC_LI   = 4'b0000;
  localparam logic [3:0] OPC_J    = 4'b0001;
  localparam logic [3:0] OPC_JZ   = 4'b0010;
  localparam logic [3:0] OPC_JNZ  = 4'b0011;
  localparam logic [3:0] OPC_NOP  = 4'b0100;
  localparam logic [3:0] OPC_HALT = 4'b0101;
  // Class is ALU whenever Opcode[5] is set.
  localparam logic       OPC_ALU_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } uc_state_e;

endpackage

// File: rtl/uc_decoder.sv
// uc_decoder: combinational instruction decode.
//   Opcode     in  6 : instruction bits [15:10]
//   z          in  1 : registered zero flag (selects the conditional-jump outcome)
//   s_inc      out 1 : 1 = PC+1, 0 = jump address
//   s_inm      out 1 : 0 = immediate, 1 = ALU result
//   we3        out 1 : register-file write
//   wez        out 1 : zero-flag write
//   Op         out 3 : ALU operation (000 for every non-ALU opcode)
//   is_halt    out 1 : opcode is HALT
//   is_illegal out 1 : opcode is undefined (011x--)
// The outputs are not gated here. The top level masks them outside EXEC.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    Op         = 3'b000;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (Opcode[5] == OPC_ALU_BIT) begin
      Op    = Opcode[4:2];
      we3   = 1'b1;
      wez   = 1'b1;
      s_inm = 1'b1;
    end else begin
      case (Opcode[5:2])
        OPC_LI:   we3 = 1'b1;
        OPC_J:    s_inc = 1'b0;
        OPC_JZ:   s_inc = ~z;
        OPC_JNZ:  s_inc = z;
        OPC_NOP:  s_inc = 1'b1;
        OPC_HALT: is_halt = 1'b1;
        // 011x--: behaves as NOP, flagged for the sticky illegal bit
        default:  is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control unit (FETCH + EXEC per instruction).
//   clk       in  1     : rising-edge clock
//   reset     in  1     : asynchronous, active-low
//   Opcode    in  6     : instruction bits [15:10]
//   z         in  1     : registered zero flag
//   run       in  1     : level, instructions execute back-to-back while high
//   step      in  1     : pulse, executes one instruction when seen in IDLE
//   s_inc/s_inm/we3/wez/Op : datapath controls, active only in EXEC
//   pc_en     out 1     : PC write enable (EXEC, except for HALT)
//   halted    out 1     : FSM is in HALT
//   illegal   out 1     : sticky, an undefined opcode was executed
//   retired   out CNT_W : completed EXEC cycles, wrapping
//   dbg_state out 2     : current FSM state (uc_state_e encoding)
//
// Run/step control: run and step are sampled only in IDLE, and run wins.
// A step start latches step mode, so the EXEC that follows returns to IDLE
// even if run rose in the meantime. run is re-examined at the end of each
// EXEC. Dropping it mid-instruction lets that instruction finish, and the
// FSM then goes to IDLE.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       dbg_state
);

  uc_state_e        state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez;
  logic [2:0] dec_op;
  logic       dec_halt, dec_illegal;
  logic       in_exec;

  uc_decoder u_dec (
    .Opcode     (Opcode),
    .z          (z),
    .s_inc      (dec_s_inc),
    .s_inm      (dec_s_inm),
    .we3        (dec_we3),
    .wez        (dec_wez),
    .Op         (dec_op),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // Derived from the asynchronously reset state register, so asserting
  // reset drops every enable without waiting for a clock edge.
  assign in_exec = (state_q == ST_EXEC);

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_halt)                 state_d = ST_HALT;
        else if (run && !step_mode_q) state_d = ST_FETCH;
        else                          state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      if (in_exec && dec_illegal) illegal_q <= 1'b1;
      if (in_exec)                retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outside EXEC, the idle values are s_inc=1 and everything else 0.
  assign s_inc     = in_exec ? dec_s_inc : 1'b1;
  assign s_inm     = in_exec & dec_s_inm;
  assign we3       = in_exec & dec_we3;
  assign wez       = in_exec & dec_wez;
  assign Op        = in_exec ? dec_op : 3'b000;
  assign pc_en     = in_exec & ~dec_halt;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule
